// File: rtl/branch_cond_gen_if.sv
// Handshake and flag bundle between the core and the
// multi-cycle branch comparator.
interface branch_cond_gen_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            flush;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            busy;
   logic            done;
   logic            valid;
   logic            f_eq;
   logic            f_ne;
   logic            f_lt;
   logic            f_ge;
   logic            f_ltu;
   logic            f_geu;
   logic            f_always;

   modport master (
      output start, flush, rs1, rs2,
      input  busy, done, valid,
      input  f_eq, f_ne, f_lt, f_ge,
      input  f_ltu, f_geu, f_always
   );

   modport slave (
      input  start, flush, rs1, rs2,
      output busy, done, valid,
      output f_eq, f_ne, f_lt, f_ge,
      output f_ltu, f_geu, f_always
   );
endinterface

// File: rtl/branch_cond_gen.sv
// Chunked MSB-first comparator producing the seven
// branch-condition mux inputs behind a start/done handshake.
module branch_cond_gen #(
   parameter int  XLEN   = 32,
   parameter int  CHUNK  = 8,
   localparam int NCHUNK = XLEN / CHUNK
) (
   input logic             clk,
   input logic             rst_n,
   branch_cond_gen_if.slave bus
);
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic            sa_q;
   logic            sb_q;
   logic [CW-1:0]   cnt_q;
   logic            dec_q;
   logic            ult_q;
   logic            done_q;
   logic            eq_q;
   logic            ne_q;
   logic            lt_q;
   logic            ge_q;
   logic            ltu_q;
   logic            geu_q;

   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic             dec_d;
   logic             ult_d;
   logic             last;
   logic             accept;
   logic             fin_ltu;
   logic             fin_lt;

   // Operands shift left each RUN cycle, so the current chunk is always on top
   assign ca      = a_q[XLEN-1 -: CHUNK];
   assign cb      = b_q[XLEN-1 -: CHUNK];
   assign dec_d   = dec_q | (ca != cb);
   assign ult_d   = dec_q ? ult_q : (ca < cb);
   assign last    = (cnt_q == LAST);
   assign fin_ltu = dec_d & ult_d;
   assign fin_lt  = (sa_q != sb_q) ? sa_q : fin_ltu;
   assign accept  = bus.start & ~bus.flush &
                    ((state_q == IDLE) | (state_q == DONE));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (bus.start) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         ult_q   <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         ne_q    <= 1'b0;
         lt_q    <= 1'b0;
         ge_q    <= 1'b0;
         ltu_q   <= 1'b0;
         geu_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == RUN) & (state_d == DONE);
         if (bus.flush || accept) begin
            eq_q  <= 1'b0;
            ne_q  <= 1'b0;
            lt_q  <= 1'b0;
            ge_q  <= 1'b0;
            ltu_q <= 1'b0;
            geu_q <= 1'b0;
         end
         if (accept) begin
            a_q   <= bus.rs1;
            b_q   <= bus.rs2;
            sa_q  <= bus.rs1[XLEN-1];
            sb_q  <= bus.rs2[XLEN-1];
            cnt_q <= '0;
            dec_q <= 1'b0;
            ult_q <= 1'b0;
         end else if (!bus.flush && state_q == RUN) begin
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
            cnt_q <= cnt_q + 1'b1;
            dec_q <= dec_d;
            ult_q <= ult_d;
            if (last) begin
               eq_q  <= ~dec_d;
               ne_q  <= dec_d;
               ltu_q <= fin_ltu;
               geu_q <= ~fin_ltu;
               lt_q  <= fin_lt;
               ge_q  <= ~fin_lt;
            end
         end
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.valid    = (state_q == DONE);
   assign bus.done     = done_q;
   assign bus.f_eq     = eq_q;
   assign bus.f_ne     = ne_q;
   assign bus.f_lt     = lt_q;
   assign bus.f_ge     = ge_q;
   assign bus.f_ltu    = ltu_q;
   assign bus.f_geu    = geu_q;
   assign bus.f_always = 1'b1;
endmodule

// File: tb/tb_branch_cond_gen.sv
// Scoreboard bench for branch_cond_gen: expected flags queued
// at start, checked against the done pulse.
module tb_branch_cond_gen;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [6:0] sb[$];
   logic [6:0] flg;

   branch_cond_gen_if #(.XLEN(32)) bus ();

   branch_cond_gen #(
      .XLEN (32),
      .CHUNK(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign flg = {bus.f_always, bus.f_geu, bus.f_ltu,
                 bus.f_ge, bus.f_lt, bus.f_ne, bus.f_eq};

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
      logic eq, ltu, lt;
      eq  = (a == b);
      ltu = (a < b);
      lt  = ($signed(a) < $signed(b));
      return {1'b1, ~ltu, ltu, ~lt, lt, ~eq, eq};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done pulse consumes one scoreboard entry
   always @(posedge clk) begin
      #1;
      if (bus.done) begin
         chk("valid_on_done", bus.valid, 1);
         if (sb.size() == 0) chk("sb_unexpected", 1, 0);
         else chk("flags", flg, sb.pop_front());
      end
   end

   task automatic wait_done(input bit jitter);
      int nb;
      bit got;
      nb  = 0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) begin
            got = 1;
            break;
         end
         if (bus.busy) nb++;
         if (jitter) begin
            bus.rs1 = $urandom;
            bus.rs2 = $urandom;
         end
         tick();
      end
      chk("done_seen", got, 1);
      if (got) chk("busy_cycles", nb, 4);
   endtask

   task automatic go(input logic [31:0] a, input logic [31:0] b);
      bus.rs1   = a;
      bus.rs2   = b;
      bus.start = 1'b1;
      sb.push_back(model(a, b));
      tick();
      bus.start = 1'b0;
      bus.rs1   = ~a;
      bus.rs2   = a ^ b;
      wait_done(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      bit seen;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.rs1   = '0;
      bus.rs2   = '0;
      tick();
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_flags", flg, 7'h40);
      rst_n = 1'b1;
      tick();

      go(32'h1234_5678, 32'h1234_5678);
      chk("eq_literal", flg, 7'b1101001);
      tick();
      chk("done_pulse", bus.done, 0);
      chk("valid_hold", bus.valid, 1);
      chk("flags_hold", flg, model(32'h1234_5678, 32'h1234_5678));

      go(32'hFFFF_FFFF, 32'h0000_0001);
      chk("neg_literal", flg, 7'b1100110);
      go(32'h0000_0100, 32'h0000_0200);
      go(32'h0000_0200, 32'h0000_0100);
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         go(r, r ^ (32'h1 << (i * 8)));
      end
      go(32'h7F00_0000, 32'h8000_0000);

      // start held through RUN with changing operands
      bus.rs1   = 32'h0000_0005;
      bus.rs2   = 32'hF000_0000;
      bus.start = 1'b1;
      sb.push_back(model(32'h0000_0005, 32'hF000_0000));
      tick();
      chk("restart_valid_drop", bus.valid, 0);
      chk("restart_busy", bus.busy, 1);
      chk("restart_flags_clr", flg, 7'h40);
      wait_done(1);
      bus.rs1 = 32'h0000_0300;
      bus.rs2 = 32'h0000_0300;
      sb.push_back(model(32'h0000_0300, 32'h0000_0300));
      tick();
      chk("second_valid_drop", bus.valid, 0);
      chk("second_busy", bus.busy, 1);
      bus.start = 1'b0;
      wait_done(0);

      // flush with start on the 2nd RUN cycle
      bus.rs1   = 32'h1111_1111;
      bus.rs2   = 32'h2222_2222;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.flush = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      chk("flush_busy", bus.busy, 0);
      chk("flush_valid", bus.valid, 0);
      chk("flush_done", bus.done, 0);
      chk("flush_flags", flg, 7'h40);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.busy || bus.done || bus.valid) seen = 1;
         tick();
      end
      chk("flush_stays_idle", seen, 0);
      go(32'hABCD_0000, 32'hABCD_0001);

      // async reset mid-RUN, between edges
      bus.rs1   = 32'h0000_0001;
      bus.rs2   = 32'h0000_0002;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_valid", bus.valid, 0);
      chk("arst_flags", flg, 7'h40);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_idle", bus.busy, 0);
      go(32'h8000_0000, 32'h7FFF_FFFF);
      chk("arst_lt", bus.f_lt, 1);
      chk("arst_ltu", bus.f_ltu, 0);

      tick();
      tick();
      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_cond_gen.md
Name: branch_cond_gen

Overview:
- Multi-cycle branch comparator directly upstream of the core's 7:1 branch-condition mux.
- Compares two XLEN operands (rs1, rs2) CHUNK bits per cycle, MSB-first.
- Produces the seven single-bit condition flags consumed as mux inputs d0..d6; the funct3-derived select then picks one.
- Uses a start/done handshake so the core can stall while the compare runs; replaces a wide single-cycle comparator to shorten the critical path.

Parameters:
- XLEN, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. XLEN mod CHUNK must be 0 and CHUNK >= 1.
- NCHUNK, XLEN/CHUNK, derived; must not be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare. Sampled only in IDLE or DONE.
- flush  input  1  synchronous abort; forces IDLE next cycle.
- rs1  input  XLEN  operand A, captured on the accepted start.
- rs2  input  XLEN  operand B, captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on entry to DONE.
- valid  output  1  flags valid; high throughout DONE.
- f_eq  output  1  mux d0: rs1 == rs2.
- f_ne  output  1  mux d1: rs1 != rs2.
- f_lt  output  1  mux d2: signed rs1 < rs2.
- f_ge  output  1  mux d3: signed rs1 >= rs2.
- f_ltu  output  1  mux d4: unsigned rs1 < rs2.
- f_geu  output  1  mux d5: unsigned rs1 >= rs2.
- f_always  output  1  mux d6: constant 1 (jump).

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - busy, done, valid, f_eq, f_ne, f_lt, f_ge, f_ltu, f_geu = 0.
  - f_always = 1 at all times, including during reset.
  - Internal operand, counter and decision registers = 0.
  - Reset mid-RUN abandons the compare with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: capture rs1/rs2 and sign bits sa=rs1[XLEN-1], sb=rs2[XLEN-1]. Clear decided and ult, set cnt=0, go to RUN.
  - RUN: each cycle compare chunk cnt, counted from MSB as bits [XLEN-1-cnt*CHUNK -: CHUNK].
    - If decided=0 and the chunks differ: set decided=1, and set ult=1 if chunkA < chunkB (unsigned).
    - Increment cnt. When cnt == NCHUNK-1, go to DONE.
    - Fixed latency: no early exit, even once decided.
  - DONE: the flag registers update on entry and are held stable while valid=1.
    - start=1 re-captures the operands and goes to RUN the next cycle; valid drops and flags return to 0.
    - Otherwise stay in DONE.
- Flag equations, registered on the RUN-to-DONE transition using the final decided/ult, including the last chunk's contribution:
  - f_eq = ~decided; f_ne = decided.
  - f_ltu = decided & ult; f_geu = ~f_ltu.
  - f_lt = (sa != sb) ? sa : f_ltu; f_ge = ~f_lt.
- Latency: start accepted at edge N; busy high for cycles N+1 .. N+NCHUNK; done and valid rise at edge N+NCHUNK. Default NCHUNK=4.
- busy is 1 exactly in RUN. done is 1 only on the first DONE cycle.
- start during RUN is ignored; no queueing, and the operands are not re-captured.
- flush has priority over start in every state.
  - Next state is IDLE, with busy/done/valid/flags cleared.
  - A start on the same cycle as flush is dropped.
- Operands change after capture: no effect on the result.
- CHUNK == XLEN (NCHUNK=1): RUN lasts one cycle; the flag rules are unchanged.

Test Plan (XLEN=32, CHUNK=8):
- Reset, then rs1=rs2=0x1234_5678 with start for 1 cycle:
  - busy high 4 cycles, then done pulse with valid=1.
  - f_eq=1, f_ne=0, f_lt=0, f_ge=1, f_ltu=0, f_geu=1, f_always=1.
- rs1=0xFFFF_FFFF, rs2=0x0000_0001: f_lt=1, f_ge=0, f_ltu=0, f_geu=1, f_ne=1.
- rs1=0x0000_0100, rs2=0x0000_0200, where the difference is only in the low 16 bits:
  - f_ltu=1, f_lt=1.
  - Swapping the operands gives f_ltu=0, f_geu=1.
- start held high through RUN while rs1/rs2 change every cycle:
  - Result matches the first-captured pair.
  - A second compare begins only from DONE, and valid drops the cycle after re-start.
- flush asserted on the 2nd RUN cycle together with start:
  - IDLE next cycle, with busy=0, valid=0, no done pulse, all flags 0 except f_always.
- rst_n pulled low asynchronously mid-RUN, between clock edges:
  - Outputs clear immediately.
  - After release, a fresh compare of rs1=0x8000_0000, rs2=0x7FFF_FFFF gives f_lt=1, f_ltu=0.
